if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/if_fetch_unit_if.sv | 36 +++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               Provides the PC width, the canonical NOP encoding, the fetch
//               FSM state type and the prefetch buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          c_PC_W = 32;
    localparam logic [31:0] c_NOP  = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [c_PC_W-1:0] pc;
        logic [31:0]       instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Instruction-memory request/acknowledge bus.
//               master : fetch unit (drives imem_req, imem_addr)
//               slave  : instruction memory (drives imem_ack, imem_data)
//               imem_req  - request, held until the ack cycle
//               imem_addr - word-aligned request address
//               imem_ack  - one-cycle completion strobe
//               imem_data - instruction word, valid with imem_ack
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if;
    import fetch_pkg::*;

    logic              imem_req;
    logic [c_PC_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small prefetch buffer holding {pc, instr} entries.
//               clk     - clock
//               rst     - synchronous active-high reset
//               i_push  - write i_data at the tail
//               i_pop   - drop the head entry
//               i_clear - empty the buffer (overrides push and pop)
//               i_data  - entry to push
//               o_count - number of valid entries
//               o_head  - oldest entry (undefined when o_count is zero)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_push,
    input  wire logic                         i_pop,
    input  wire logic                         i_clear,
    input  wire fetch_entry_t                 i_data,
    output logic [$clog2(DEPTH+1)-1:0]        o_count,
    output fetch_entry_t                      o_head
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(i_push) - c_CNT_W'(i_pop);
        end
    end

    // Storage needs no reset: o_count qualifies every read of the head.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch stage with a 2-entry prefetch buffer and a
//               single outstanding memory request. Redirects (Flush_i) empty
//               the buffer; a request in flight at redirect time is completed
//               on the bus and its data discarded.
//               clk_i          - clock
//               rst_i          - synchronous active-high reset
//               start_i        - run enable (no new fetch, no pop when low)
//               Stall_i        - hold from hazard unit (no pop when high)
//               Flush_i        - redirect strobe
//               BranchTarget_i - redirect address
//               imem           - instruction-memory bus (master side)
//               pc_o/instr_o   - head entry (0 / NOP when empty)
//               valid_o        - head entry present
//               Build option FETCH_BYPASS_EN: an ack arriving while the
//               buffer is empty is presented on the outputs in the same
//               cycle instead of one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [c_PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              start_i,
    input  wire logic              Stall_i,
    input  wire logic              Flush_i,
    input  wire logic [c_PC_W-1:0] BranchTarget_i,
    if_fetch_unit_if.master        imem,
    output logic [c_PC_W-1:0]      pc_o,
    output logic [31:0]            instr_o,
    output logic                   valid_o
);

    localparam int                 c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic [c_PC_W-1:0]   r_fetch_pc;
    logic [c_PC_W-1:0]   w_fetch_pc_next;
    logic [c_PC_W-1:0]   r_stale_addr;
    logic [c_PC_W-1:0]   w_stale_addr_next;
    logic [c_CNT_W-1:0]  w_count;
    logic [c_CNT_W-1:0]  w_count_next;
    fetch_entry_t        w_head;
    fetch_entry_t        w_push_entry;
    logic                w_head_valid;
    logic                w_ack;
    logic                w_bypass;
    logic                w_pop;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic                w_room;

    // Only an ack for a live (non-discarded) request carries useful data.
    assign w_ack        = imem.imem_ack && (r_state == REQ);
    assign w_head_valid = (w_count != '0);

    // ------------------------------------------------------------------
    // Output presentation
    // ------------------------------------------------------------------
    always_comb begin
        w_bypass = 1'b0;
        valid_o  = w_head_valid;
        pc_o     = '0;
        instr_o  = c_NOP;
        if (w_head_valid) begin
            pc_o    = w_head.pc;
            instr_o = w_head.instr;
        end
`ifdef FETCH_BYPASS_EN
        if ((w_count == '0) && w_ack && !Flush_i) begin
            w_bypass = 1'b1;
            valid_o  = 1'b1;
            pc_o     = r_fetch_pc;
            instr_o  = imem.imem_data;
        end
`endif
    end

    // A flush wins over everything: no pop, no push, buffer cleared.
    assign w_pop        = valid_o && start_i && !Stall_i && !Flush_i;
    assign w_fifo_pop   = w_pop && !w_bypass;
    // A bypassed word consumed this cycle never enters the buffer.
    assign w_fifo_push  = w_ack && !Flush_i && !(w_bypass && w_pop);
    assign w_push_entry = '{pc: r_fetch_pc, instr: imem.imem_data};

    assign w_count_next = Flush_i ? '0
                                  : (w_count + c_CNT_W'(w_fifo_push) - c_CNT_W'(w_fifo_pop));
    // A new request is only issued if its data is guaranteed a slot.
    assign w_room       = start_i && (w_count_next < c_FULL);

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_clear (Flush_i),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= RESET_PC;
        end else begin
            r_fetch_pc   <= w_fetch_pc_next;
            r_stale_addr <= w_stale_addr_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_stale_addr_next = r_stale_addr;
        imem.imem_req     = 1'b0;
        imem.imem_addr    = r_fetch_pc;
        case (r_state)
            IDLE: begin
                if (Flush_i) begin
                    w_fetch_pc_next = BranchTarget_i;
                end
                if (w_room) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                imem.imem_req = 1'b1;
                if (Flush_i) begin
                    w_fetch_pc_next = BranchTarget_i;
                    if (!imem.imem_ack) begin
                        // Request still in flight: keep its address on the
                        // bus until the memory answers, then drop the data.
                        w_state_next      = DISCARD;
                        w_stale_addr_next = r_fetch_pc;
                    end
                end else if (imem.imem_ack) begin
                    w_fetch_pc_next = r_fetch_pc + c_PC_W'(4);
                    if (!w_room) begin
                        w_state_next = IDLE;
                    end
                end
            end
            DISCARD: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = r_stale_addr;
                if (Flush_i) begin
                    w_fetch_pc_next = BranchTarget_i;
                end
                if (imem.imem_ack) begin
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. A table of per-cycle
//               input/expected-output vectors drives the memory bus and
//               control inputs directly; short hand-written sequences cover
//               slower ack latency and the bypass build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;
    import fetch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        Stall_i;
    logic        Flush_i;
    logic [31:0] BranchTarget_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .Stall_i        (Stall_i),
        .Flush_i        (Flush_i),
        .BranchTarget_i (BranchTarget_i),
        .imem           (bus),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .valid_o        (valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        start;
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] dat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic st, input logic f,
                         input logic [31:0] tgt, input logic a, input logic [31:0] d);
        rst_i          = r;
        start_i        = s;
        Stall_i        = st;
        Flush_i        = f;
        BranchTarget_i = tgt;
        bus.imem_ack   = a;
        bus.imem_data  = d;
    endtask

    task automatic add(input logic r, input logic s, input logic st, input logic f,
                       input logic [31:0] tgt, input logic a, input logic [31:0] d,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rst = r; v.start = s; v.stall = st; v.flush = f; v.tgt = tgt;
        v.ack = a; v.dat = d; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_pc,
                                 input logic [31:0] e_instr);
        check({tag, " req"},   32'(bus.imem_req), 32'(e_req));
        check({tag, " addr"},  bus.imem_addr,     e_addr);
        check({tag, " valid"}, 32'(valid_o),      32'(e_valid));
        check({tag, " pc"},    pc_o,              e_pc);
        check({tag, " instr"}, instr_o,           e_instr);
    endtask

    // Bounded wait for imem_req; an expired bound is a failed comparison.
    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.imem_req && n < 8) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check({tag, " req seen"}, 32'(bus.imem_req), 32'd1);
    endtask

    initial begin
        apply(1, 0, 0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk_i);

`ifndef FETCH_BYPASS_EN
        //  rst st stl fl tgt          ack dat             req addr        vld pc          instr
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h0,       c_NOP);        // reset state
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h0,       0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       1, 32'hA000_0000,  1, 32'h0,       0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h4,       1, 32'h0,       32'hA000_0000);
        add(0, 1, 0, 0, 32'h0,       1, 32'hA000_0004,  1, 32'h4,       0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h8,       1, 32'h4,       32'hA000_0004);
        add(0, 1, 0, 0, 32'h0,       1, 32'hA000_0008,  1, 32'h8,       0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'hC,       1, 32'h8,       32'hA000_0008);
        // stall for five cycles while the buffer fills
        add(0, 1, 1, 0, 32'h0,       1, 32'hA000_000C,  1, 32'hC,       0, 32'h0,       c_NOP);
        add(0, 1, 1, 0, 32'h0,       0, 32'h0,          1, 32'h10,      1, 32'hC,       32'hA000_000C);
        add(0, 1, 1, 0, 32'h0,       1, 32'hA000_0010,  1, 32'h10,      1, 32'hC,       32'hA000_000C);
        add(0, 1, 1, 0, 32'h0,       0, 32'h0,          0, 32'h14,      1, 32'hC,       32'hA000_000C);
        add(0, 1, 1, 0, 32'h0,       0, 32'h0,          0, 32'h14,      1, 32'hC,       32'hA000_000C);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          0, 32'h14,      1, 32'hC,       32'hA000_000C);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h14,      1, 32'h10,      32'hA000_0010);
        add(0, 1, 0, 0, 32'h0,       1, 32'hA000_0014,  1, 32'h14,      0, 32'h0,       c_NOP);
        // flush to 0x100 with a request pending; stale ack three cycles later
        add(0, 1, 0, 1, 32'h100,     0, 32'h0,          1, 32'h18,      1, 32'h14,      32'hA000_0014);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h18,      0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h18,      0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       1, 32'hDEAD_BEEF,  1, 32'h18,      0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h100,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       1, 32'hA000_0100,  1, 32'h100,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h104,     1, 32'h100,     32'hA000_0100);
        // flush and ack in the same cycle, target 0x200
        add(0, 1, 0, 1, 32'h200,     1, 32'hBADB_AD00,  1, 32'h104,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h200,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       1, 32'hA000_0200,  1, 32'h200,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h204,     1, 32'h200,     32'hA000_0200);
        // second flush while discarding retargets; bus address holds
        add(0, 1, 0, 1, 32'h300,     0, 32'h0,          1, 32'h204,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 1, 32'h400,     0, 32'h0,          1, 32'h204,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       1, 32'h1111_1111,  1, 32'h204,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h400,     0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       1, 32'hA000_0400,  1, 32'h400,     0, 32'h0,       c_NOP);
        // start low: no pop, outstanding request completes, then idle
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,          1, 32'h404,     1, 32'h400,     32'hA000_0400);
        add(0, 0, 0, 0, 32'h0,       1, 32'hA000_0404,  1, 32'h404,     1, 32'h400,     32'hA000_0400);
        add(0, 0, 0, 0, 32'h0,       1, 32'h2222_2222,  0, 32'h408,     1, 32'h400,     32'hA000_0400);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h408,     1, 32'h400,     32'hA000_0400);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          0, 32'h408,     1, 32'h400,     32'hA000_0400);
        // reset while a request is outstanding and the buffer is non-empty
        add(1, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h408,     1, 32'h404,     32'hA000_0404);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h0,       c_NOP);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h0,       0, 32'h0,       c_NOP);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            apply(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].flush,
                  vecs[i].tgt, vecs[i].ack, vecs[i].dat);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
        end

        // Ack three cycles into a request: address held, data visible next cycle.
        @(negedge clk_i);
        apply(0, 1, 1, 0, 32'h0, 0, 32'h0);
        #1;
        wait_req("lat3");
        check("lat3 addr hold 1", bus.imem_addr, 32'h0);
        @(negedge clk_i);
        #1;
        check("lat3 addr hold 2", bus.imem_addr, 32'h0);
        @(negedge clk_i);
        apply(0, 1, 1, 0, 32'h0, 1, 32'h0050_0093);
        #1;
        check("lat3 ack cycle valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        apply(0, 1, 1, 0, 32'h0, 0, 32'h0);
        #1;
        check_outputs("lat3 after", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0050_0093);
`else
        // Empty buffer, ack at 0x0: data presented in the ack cycle.
        @(negedge clk_i);
        apply(0, 1, 1, 0, 32'h0, 0, 32'h0);
        #1;
        check_outputs("byp reset", 1'b0, 32'h0, 1'b0, 32'h0, c_NOP);
        wait_req("byp");
        @(negedge clk_i);
        apply(0, 1, 1, 0, 32'h0, 1, 32'h0050_0093);
        #1;
        check_outputs("byp ack", 1'b1, 32'h0, 1'b1, 32'h0, 32'h0050_0093);
        @(negedge clk_i);
        apply(0, 1, 1, 0, 32'h0, 0, 32'h0);
        #1;
        check_outputs("byp held", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0050_0093);
        @(negedge clk_i);
        apply(0, 1, 0, 0, 32'h0, 0, 32'h0);
        #1;
        @(negedge clk_i);
        #1;
        check("byp popped valid", 32'(valid_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
